same_idx_scan: RTL and testbench

Sequential scanner that reads a DEPTH-entry data memory and reports every index whose stored value equals a key. It produces the 5-bit index values consumed downstream by the same-index register, and drives the memory read port. It sits between the control FSM (start/clr), the sample memory (read port) and the index-capture logic (valid/ready stream).

---
 rtl/same_idx_pkg.sv | 17 +
 rtl/same_idx_cnt.sv | 33 +++
 rtl/same_idx_scan.sv | 134 +++++++++++++
 tb/tb_same_idx_scan.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/same_idx_pkg.sv
// Shared types and default sizing for the same-index scanner.
package same_idx_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_DEPTH  = 32;
    localparam int unsigned DEF_IDX_W  = $clog2(DEF_DEPTH);
    localparam int unsigned LEN_W      = DEF_IDX_W + 1;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWait,
        StEmit,
        StDone
    } state_e;

endpackage

// File: rtl/same_idx_cnt.sv
// Scan address counter: zero on clr/load, step on inc, flags the last entry of the scan.
module same_idx_cnt
    import same_idx_pkg::*;
#(
    parameter int unsigned IDX_W = DEF_IDX_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             load,
    input  logic             inc,
    input  logic [IDX_W:0]   len,
    output logic [IDX_W-1:0] addr,
    output logic             last
);

    logic [IDX_W-1:0] addr_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_q <= '0;
        end else if (clr || load) begin
            addr_q <= '0;
        end else if (inc) begin
            addr_q <= addr_q + 1'b1;
        end
    end

    // Compared at IDX_W+1 bits so len == DEPTH maps to last index DEPTH-1 without wrapping.
    assign last = ({1'b0, addr_q} == (len - 1'b1));
    assign addr = addr_q;

endmodule

// File: rtl/same_idx_scan.sv
// Scans len memory entries and streams out every index whose word equals the latched key.
module same_idx_scan
    import same_idx_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned IDX_W  = DEF_IDX_W
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              clr,
    input  logic [DATA_W-1:0] key,
    input  logic [IDX_W:0]    len,
    output logic              mem_rd,
    output logic [IDX_W-1:0]  mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic [IDX_W-1:0]  idx_o,
    output logic              idx_valid,
    input  logic              idx_ready,
    output logic              busy,
    output logic              done,
    output logic [IDX_W:0]    match_cnt
);

    localparam logic [IDX_W:0] LEN_MAX = (IDX_W + 1)'(DEPTH);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] key_q;
    logic [IDX_W:0]    len_q, len_sat, match_cnt_q;
    logic [IDX_W-1:0]  idx_q, addr;
    logic              mem_rd_q, idx_valid_q, busy_q, done_q;
    logic              start_acc, hit, inc, last;

    assign len_sat = (len > LEN_MAX) ? LEN_MAX : len;

    same_idx_cnt #(
        .IDX_W(IDX_W)
    ) u_cnt (
        .clk (clk),
        .rstn(rstn),
        .clr (clr),
        .load(start_acc),
        .inc (inc),
        .len (len_q),
        .addr(addr),
        .last(last)
    );

    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        hit       = 1'b0;
        inc       = 1'b0;
        if (clr) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        start_acc = 1'b1;
                        state_d   = (len_sat == '0) ? StDone : StRead;
                    end
                end
                StRead: state_d = StWait;
                StWait: begin
                    if (mem_data == key_q) begin
                        hit     = 1'b1;
                        state_d = StEmit;
                    end else if (last) begin
                        state_d = StDone;
                    end else begin
                        inc     = 1'b1;
                        state_d = StRead;
                    end
                end
                StEmit: begin
                    if (idx_ready) begin
                        if (last) begin
                            state_d = StDone;
                        end else begin
                            inc     = 1'b1;
                            state_d = StRead;
                        end
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // Output flags are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            key_q       <= '0;
            len_q       <= '0;
            match_cnt_q <= '0;
            idx_q       <= '0;
            mem_rd_q    <= 1'b0;
            idx_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_acc) begin
                key_q <= key;
                len_q <= len_sat;
            end
            if (clr || start_acc) begin
                match_cnt_q <= '0;
            end else if (hit) begin
                match_cnt_q <= match_cnt_q + 1'b1;
            end
            if (hit) begin
                idx_q <= addr;
            end
            mem_rd_q    <= (state_d == StRead);
            idx_valid_q <= (state_d == StEmit);
            busy_q      <= (state_d != StIdle);
            done_q      <= (state_d == StDone);
        end
    end

    assign mem_rd    = mem_rd_q;
    assign mem_addr  = addr;
    assign idx_o     = idx_q;
    assign idx_valid = idx_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign match_cnt = match_cnt_q;

endmodule

// File: tb/tb_same_idx_scan.sv
// Directed bench for same_idx_scan: table of whole scans plus hand sequences for stall/abort/reset.
module tb_same_idx_scan;
    import same_idx_pkg::*;

    logic       clk = 1'b0;
    logic       rstn, start, clr, idx_ready;
    logic [7:0] key, mem_data;
    logic [5:0] len, match_cnt;
    logic [4:0] mem_addr, idx_o;
    logic       mem_rd, idx_valid, busy, done;

    always #5 clk = ~clk;

    same_idx_scan dut (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
        .clr      (clr),
        .key      (key),
        .len      (len),
        .mem_rd   (mem_rd),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .idx_o    (idx_o),
        .idx_valid(idx_valid),
        .idx_ready(idx_ready),
        .busy     (busy),
        .done     (done),
        .match_cnt(match_cnt)
    );

    // Memory model: data valid the cycle after the read strobe.
    logic [7:0] mem [32];
    always_ff @(posedge clk) begin
        if (mem_rd) mem_data <= mem[mem_addr];
    end

    int         mon_rd = 0, mon_emit = 0, mon_done = 0, mon_busy = 0;
    logic [4:0] last_rd = '0;
    logic [4:0] emit_log [256];
    always_ff @(posedge clk) begin
        if (mem_rd) begin
            mon_rd  <= mon_rd + 1;
            last_rd <= mem_addr;
        end
        if (idx_valid && idx_ready) begin
            emit_log[mon_emit[7:0]] <= idx_o;
            mon_emit <= mon_emit + 1;
        end
        if (done) mon_done <= mon_done + 1;
        if (busy) mon_busy <= mon_busy + 1;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic load_mem(input logic [7:0] fill, input int a, input int b,
                            input logic [7:0] val);
        for (int i = 0; i < 32; i++) mem[i] = fill;
        if (a >= 0) mem[a] = val;
        if (b >= 0) mem[b] = val;
    endtask

    typedef struct {
        string      name;
        logic [7:0] fill;
        int         sp_a;
        int         sp_b;
        logic [7:0] sp_val;
        logic [7:0] key;
        logic [5:0] len;
        int         exp_cnt;
        int         exp_cyc;
        int         exp_first;
        int         exp_last;
        int         exp_rd;
    } vec_t;

    vec_t vecs [7];

    task automatic run_vec(input vec_t v);
        int s_rd, s_emit, s_done, s_busy, cyc;
        load_mem(v.fill, v.sp_a, v.sp_b, v.sp_val);
        s_rd   = mon_rd;
        s_emit = mon_emit;
        s_done = mon_done;
        s_busy = mon_busy;
        key = v.key;
        len = v.len;
        idx_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        check({v.name, "_done_cycle"}, cyc, v.exp_cyc);
        check({v.name, "_match_cnt"}, match_cnt, v.exp_cnt);
        check({v.name, "_idle_busy"}, busy, 0);
        check({v.name, "_emits"}, mon_emit - s_emit, v.exp_cnt);
        check({v.name, "_reads"}, mon_rd - s_rd, v.exp_rd);
        check({v.name, "_done_pulses"}, mon_done - s_done, 1);
        check({v.name, "_busy_cycles"}, mon_busy - s_busy, v.exp_cyc);
        if (v.exp_cnt > 0) begin
            check({v.name, "_first_idx"}, emit_log[s_emit[7:0]], v.exp_first);
            check({v.name, "_last_idx"}, emit_log[(mon_emit - 1) & 255], v.exp_last);
        end
        if (v.exp_rd > 0) check({v.name, "_last_addr"}, last_rd, v.exp_rd - 1);
    endtask

    initial begin
        int   c, s_done;
        vec_t post_rst;
        //               name       fill  a   b   val    key    len  cnt cyc fst lst rd
        vecs[0] = '{"all_match", 8'h2A, -1, -1, 8'h00, 8'h2A, 6'd4, 4, 13, 0, 3, 4};
        vecs[1] = '{"sparse", 8'h00, 5, 31, 8'h7F, 8'h7F, 6'd32, 2, 67, 5, 31, 32};
        vecs[2] = '{"len_zero", 8'h00, -1, -1, 8'h00, 8'h00, 6'd0, 0, 1, 0, 0, 0};
        vecs[3] = '{"len_sat", 8'h00, 5, 31, 8'h7F, 8'h7F, 6'd40, 2, 67, 5, 31, 32};
        vecs[4] = '{"no_match", 8'h11, -1, -1, 8'h00, 8'h22, 6'd10, 0, 21, 0, 0, 10};
        vecs[5] = '{"last_only", 8'h00, 6, -1, 8'h55, 8'h55, 6'd7, 1, 16, 6, 6, 7};
        vecs[6] = '{"single", 8'h00, 0, -1, 8'h09, 8'h09, 6'd1, 1, 4, 0, 0, 1};
        post_rst = '{"rescan", 8'h11, -1, -1, 8'h00, 8'h11, 6'd3, 3, 10, 0, 2, 3};

        rstn = 1'b0; start = 1'b0; clr = 1'b0; idx_ready = 1'b1; key = '0; len = '0;
        load_mem(8'h00, -1, -1, 8'h00);
        repeat (3) @(negedge clk);
        check("reset_outputs", {mem_rd, mem_addr, idx_o, idx_valid, busy, done, match_cnt}, 0);
        rstn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Backpressure: match at 3 held for 5 stalled cycles, then accepted.
        load_mem(8'h00, 3, -1, 8'hAA);
        key = 8'hAA; len = 6'd6; idx_ready = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (c = 0; c < 50 && !idx_valid; c++) @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            check("bp_valid_held", idx_valid, 1);
            check("bp_idx_held", idx_o, 3);
            check("bp_no_read", mem_rd, 0);
            if (k == 5) idx_ready = 1'b1;
            @(negedge clk);
        end
        check("bp_resume_rd", mem_rd, 1);
        check("bp_resume_addr", mem_addr, 4);
        for (c = 0; c < 50 && !done; c++) @(negedge clk);
        check("bp_done", done, 1);
        check("bp_match_cnt", match_cnt, 1);
        @(negedge clk);

        // Abort during EMIT at idx 2, with start held alongside clr.
        load_mem(8'h00, 2, -1, 8'h05);
        key = 8'h05; len = 6'd8; idx_ready = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (c = 0; c < 50 && !idx_valid; c++) @(negedge clk);
        check("abort_emit_idx", idx_o, 2);
        check("abort_cnt_before", match_cnt, 1);
        s_done = mon_done;
        clr = 1'b1; start = 1'b1;
        @(negedge clk);
        check("abort_valid", idx_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_match_cnt", match_cnt, 0);
        check("abort_done", done, 0);
        @(negedge clk);
        check("abort_start_ignored", busy, 0);
        clr = 1'b0; start = 1'b0; idx_ready = 1'b1;
        @(negedge clk);
        check("abort_still_idle", busy, 0);
        check("abort_no_done_pulse", mon_done - s_done, 0);

        // Reset in the WAIT of entry 2.
        load_mem(8'h11, -1, -1, 8'h00);
        key = 8'h11; len = 6'd4; idx_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (c = 0; c < 50 && !(mem_rd && mem_addr == 5'd2); c++) @(negedge clk);
        @(negedge clk);
        check("rst_pre_busy", busy, 1);
        check("rst_pre_cnt", match_cnt, 2);
        check("rst_pre_addr", mem_addr, 2);
        rstn = 1'b0;
        #1;
        check("rst_async_outputs",
              {mem_rd, mem_addr, idx_o, idx_valid, busy, done, match_cnt}, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        run_vec(post_rst);

        // Start while busy must not disturb the latched key/len.
        load_mem(8'h44, -1, -1, 8'h00);
        for (int i = 0; i < 4; i++) mem[i] = 8'h33;
        key = 8'h33; len = 6'd4; idx_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 1;
        repeat (2) begin
            @(negedge clk);
            c++;
        end
        key = 8'h44; len = 6'd20; start = 1'b1;
        @(negedge clk);
        c++;
        start = 1'b0;
        while (!done && c < 300) begin
            @(negedge clk);
            c++;
        end
        check("busy_start_done_cycle", c, 13);
        @(negedge clk);
        check("busy_start_match_cnt", match_cnt, 4);
        check("busy_start_last_addr", last_rd, 3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
